// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: state encoding,
// opcode values and the operand-signedness decode also used by the ALU.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Every code with bit 0 set belongs to this unit; the ALU keeps the rest.
  localparam logic [4:0] OP_MUL    = 5'b00001;
  localparam logic [4:0] OP_MULH   = 5'b00011;
  localparam logic [4:0] OP_MULHSU = 5'b00101;
  localparam logic [4:0] OP_MULHU  = 5'b00111;
  localparam logic [4:0] OP_DIV    = 5'b01001;
  localparam logic [4:0] OP_DIVU   = 5'b01011;
  localparam logic [4:0] OP_REM    = 5'b01101;
  localparam logic [4:0] OP_REMU   = 5'b01111;

  function automatic logic md_signed_x(input logic [4:0] code);
    return (code == OP_MUL) || (code == OP_MULH) || (code == OP_MULHSU) ||
           (code == OP_DIV) || (code == OP_REM);
  endfunction

  function automatic logic md_signed_y(input logic [4:0] code);
    return (code == OP_MUL) || (code == OP_MULH) || (code == OP_DIV) || (code == OP_REM);
  endfunction

  function automatic logic md_is_div(input logic [4:0] code);
    return (code == OP_DIV) || (code == OP_DIVU) || (code == OP_REM) || (code == OP_REMU);
  endfunction

  function automatic logic md_is_rem(input logic [4:0] code);
    return (code == OP_REM) || (code == OP_REMU);
  endfunction

  function automatic logic md_is_defined(input logic [4:0] code);
    return (code == OP_MUL) || (code == OP_MULH) || (code == OP_MULHSU) ||
           (code == OP_MULHU) || md_is_div(code);
  endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// One iteration bit of the shared multiply/divide datapath.
// mode=0: shift-add multiply; {hi,lo} is the 2*XLEN accumulator whose low
//         half starts as the multiplier and shifts right each step.
// mode=1: restoring divide; hi is the partial remainder, lo the dividend
//         shifting left while quotient bits enter at the bottom.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            mode,
  input  logic [XLEN-1:0] hi_in,
  input  logic [XLEN-1:0] lo_in,
  input  logic [XLEN-1:0] y,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] diff;
  logic            fits;

  // Compute both step flavours and select by mode.
  always_comb begin
    sum    = {1'b0, hi_in} + (lo_in[0] ? {1'b0, y} : '0);
    trial  = {hi_in, lo_in[XLEN-1]};
    fits   = (trial >= {1'b0, y});
    // The remainder is always below y, so the difference fits in XLEN bits.
    diff   = trial[XLEN-1:0] - y;
    hi_out = sum[XLEN:1];
    lo_out = {sum[0], lo_in[XLEN-1:1]};
    if (mode) begin
      hi_out = fits ? diff : trial[XLEN-1:0];
      lo_out = {lo_in[XLEN-2:0], fits};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit.
// Handshake: a request transfers on a cycle where in_valid && in_ready and
// flush is low; a result transfers on a cycle where out_valid && out_ready.
// out_valid, result and out_tag stay stable until that transfer happens.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alucode,
  input  logic [XLEN-1:0]  r1,
  input  logic [XLEN-1:0]  r2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int ITER  = XLEN / UNROLL;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   hi_q, lo_q, y_q;
  logic [4:0]        op_q;
  logic              neg_x_q, neg_y_q;

  logic              accept, fast;
  logic              x_neg, y_neg;
  logic [XLEN-1:0]   x_mag, y_mag, fast_res, fix_res;
  logic [2*XLEN-1:0] prod, prod_fix;

  logic [XLEN-1:0]   chain_hi [UNROLL+1];
  logic [XLEN-1:0]   chain_lo [UNROLL+1];

  assign in_ready = (state_q == MD_IDLE) && !rst;

  // Operand magnitudes, sign flags and the early-out decode at accept time.
  always_comb begin
    x_neg    = md_signed_x(alucode) & r1[XLEN-1];
    y_neg    = md_signed_y(alucode) & r2[XLEN-1];
    x_mag    = x_neg ? (~r1 + 1'b1) : r1;
    y_mag    = y_neg ? (~r2 + 1'b1) : r2;
    fast     = 1'b1;
    fast_res = '0;
    if (!md_is_defined(alucode)) begin
      fast_res = '0;
    end else if (md_is_div(alucode) && (r2 == '0)) begin
      fast_res = md_is_rem(alucode) ? r1 : '1;
    end else if (((alucode == OP_DIV) || (alucode == OP_REM)) && (r1 == MIN_VAL) && (r2 == '1)) begin
      fast_res = (alucode == OP_REM) ? '0 : MIN_VAL;
    end else begin
      fast = 1'b0;
    end
  end

  // Sign fixup and result selection from the finished accumulator.
  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = (neg_x_q ^ neg_y_q) ? (~prod + 1'b1) : prod;
    case (op_q)
      OP_MUL:                       fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV:                       fix_res = (neg_x_q ^ neg_y_q) ? (~lo_q + 1'b1) : lo_q;
      OP_DIVU:                      fix_res = lo_q;
      OP_REM:                       fix_res = neg_x_q ? (~hi_q + 1'b1) : hi_q;
      OP_REMU:                      fix_res = hi_q;
      default:                      fix_res = '0;
    endcase
  end

  assign chain_hi[0] = hi_q;
  assign chain_lo[0] = lo_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .mode   (md_is_div(op_q)),
      .hi_in  (chain_hi[g]),
      .lo_in  (chain_lo[g]),
      .y      (y_q),
      .hi_out (chain_hi[g+1]),
      .lo_out (chain_lo[g+1])
    );
  end

  // Next-state decode; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (in_valid && in_ready && !flush) begin
          accept  = 1'b1;
          state_d = fast ? MD_DONE : MD_CALC;
        end
      end
      MD_CALC: if (cnt_q == '0) state_d = MD_DONE;
      MD_DONE: if (out_ready) state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (flush) state_d = MD_IDLE;
  end

  // State register and the registered valid flag that mirrors DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MD_IDLE;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d == MD_DONE);
    end
  end

  // Datapath: latch on accept, iterate in CALC, register the fixed-up result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      result  <= '0;
      out_tag <= '0;
    end else if (accept) begin
      op_q    <= alucode;
      out_tag <= in_tag;
      neg_x_q <= x_neg;
      neg_y_q <= y_neg;
      y_q     <= y_mag;
      hi_q    <= '0;
      lo_q    <= x_mag;
      cnt_q   <= CNT_W'(ITER);
      if (fast) result <= fast_res;
    end else if ((state_q == MD_CALC) && !flush) begin
      if (cnt_q == '0) begin
        result <= fix_res;
      end else begin
        hi_q  <= chain_hi[UNROLL];
        lo_q  <= chain_lo[UNROLL];
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised, multi-cycle integer multiply/divide unit for the RV32M instruction group: MUL, MULH (`MULU`), MULHSU, MULHU, DIV, DIVU, REM, REMU. It takes its opcode from the shared `alucode` field. It sits beside the single-cycle ALU in the execute stage and takes over every alucode with bit 0 set. The ALU then no longer needs its combinational 64-bit multiplier and divider. Handshaking is valid/ready on both sides, with a tag passthrough and a pipeline flush. Throughput is configurable, from 1 to 4 iteration bits per cycle.

## Interface
Parameters:
- `XLEN`, 32: operand and result width. Must be even and ≥ 8.
- `UNROLL`, 1: iteration bits retired per cycle. Allowed values are 1, 2 or 4, and `UNROLL` must divide `XLEN`.
- `TAG_W`, 5: width of the opaque tag (the destination register index).

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `flush` in 1: abandons any op in flight.
- `in_valid` in 1: request valid.
- `in_ready` out 1: unit can accept a request.
- `alucode` in 5: opcode, using the `` `MUL ``…`` `REMU `` codes from 99_define.v.
- `r1` in XLEN: dividend or multiplicand (x).
- `r2` in XLEN: divisor or multiplier (y).
- `in_tag` in TAG_W: tag, carried through unchanged.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `result` out XLEN: the result.
- `out_tag` out TAG_W: tag of the current result.

## Operation
- The state machine has three states: IDLE, CALC and DONE. `in_ready` = (state==IDLE) && !rst.
- **Accept** happens when in_valid && in_ready. On accept the unit latches the opcode and tag, plus the operand magnitudes and sign flags:
  - x is signed for MUL, MULH, MULHSU, DIV and REM.
  - y is signed for MUL, MULH, DIV and REM.
  - A negative signed operand is replaced by its two's complement (|MIN| = MIN, treated unsigned).
- **Fast path**: the unit goes IDLE→DONE directly and skips CALC in these cases:
  - y==0 with a div-family opcode. The result is all-ones for DIV/DIVU and x for REM/REMU.
  - DIV/REM with x==MIN and y==−1. The result is MIN for DIV and 0 for REM.
  - alucode with bit0==0, or any undefined code. The result is 0.
- **CALC**: the counter loads `XLEN/UNROLL`. Each cycle performs UNROLL steps and decrements the counter.
  - Multiply step: shift-add into a 2·XLEN accumulator.
  - Divide step: restoring step on the {remainder, quotient} register pair.
  - When the counter reaches 0 the unit goes to DONE.
- **Sign fixup** is applied on the CALC→DONE edge, and the result is registered.
  - Product: negated over 2·XLEN if signx^signy (per the signedness above).
  - MUL takes the low XLEN bits. MULH, MULHSU and MULHU take the high XLEN bits.
  - Quotient: negated if signx^signy (DIV only).
  - Remainder: negated if signx (REM only).
- **DONE**: `out_valid`=1, with `result` and `out_tag` held stable. On out_ready the unit goes to IDLE.
- **flush**: from any state the unit goes to IDLE on the next edge, and out_valid drops on that edge. Flush takes priority over accept and over the DONE→IDLE hand-off. A request presented in the same cycle as flush is not accepted.
- **rst**: has the same effect as flush. In addition it sets `result`=0, `out_tag`=0 and the counter to 0.

## Timing
- All outputs are registered except `in_ready`, which is decoded from state.
- Reset values: out_valid 0, result 0, out_tag 0, and in_ready 0 while rst is high (1 from the first cycle after rst).
- Normal latency, for accept at edge N: out_valid rises at edge N + XLEN/UNROLL + 1.
  - XLEN=32, UNROLL=1: 33 cycles.
  - XLEN=32, UNROLL=4: 9 cycles.
- Fast path latency: out_valid rises at edge N+1.
- Throughput is one op in flight. The next accept comes no earlier than the cycle after the out_valid && out_ready cycle, because in_ready is low in DONE.
- While out_valid=1 and out_ready=0, `result` and `out_tag` hold indefinitely.
- Counter width is $clog2(XLEN/UNROLL+1).
- Operands may change after accept without effect on the op.

## Structure
- Additions to 99_define.v:
  - State encodings `MD_IDLE`, `MD_CALC` and `MD_DONE`.
  - A `MD_SIGNED_X`/`MD_SIGNED_Y` decode macro, or a function include, shared with the ALU.
- The natural sub-module is `muldiv_step`. It is the combinational single-bit step (add/shift and trial-subtract/restore, selected by a mode bit) and is instantiated UNROLL times in a chain by generate.
- Target size is 200–300 lines of RTL.

## Test plan
All scenarios use XLEN=32 and UNROLL=1 unless a line states otherwise.
- **MUL and MULH**: MUL x=7, y=0xFFFFFFFD → result 0xFFFFFFEB and out_tag = in_tag, with out_valid exactly 33 cycles after accept. MULH on the same operands → 0xFFFFFFFF.
- **MULHU and MULHSU**: MULHU x=y=0xFFFFFFFF → 0xFFFFFFFE. MULHSU x=0xFFFFFFFF (−1), y=0xFFFFFFFF → 0xFFFFFFFF. MULHSU x=0x80000000, y=2 → 0xFFFFFFFF.
- **Signed divide**: DIV x=−7, y=2 → 0xFFFFFFFD. REM on the same operands → 0xFFFFFFFF. DIVU x=0xFFFFFFF9, y=2 → 0x7FFFFFFC. With UNROLL=4 the same values appear with 9-cycle latency.
- **Fast-path corners**: each of the following gives out_valid at accept+1.
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5%0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM on the same operands → 0.
- **Backpressure**: hold out_ready low for 10 cycles in DONE → result and out_tag stay constant and in_ready stays 0. One cycle of out_ready → in_ready=1 on the next cycle, and a back-to-back op is accepted and gives the correct result.
- **Flush and reset**:
  - Assert flush at CALC cycle 10 together with a new in_valid → out_valid never rises for the aborted op, the new request is not taken, and in_ready=1 next cycle.
  - rst mid-CALC → outputs return to their reset values, and the following op DIVU 100/7 → 14.
